// File: rtl/sym_pkg.sv
// Shared definitions for the symmetry-detector front end: FSM state codes,
// counter width, default parameters and a saturating increment helper.
package sym_pkg;

  localparam int SYM_CNT_W   = 8;
  localparam int DEF_N       = 8;
  localparam int DEF_TIMEOUT = 64;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SHIFT = 3'd1;
  localparam state_t ST_ISSUE = 3'd2;
  localparam state_t ST_LOAD  = 3'd3;
  localparam state_t ST_WAIT  = 3'd4;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [SYM_CNT_W-1:0] sat_inc(input logic [SYM_CNT_W-1:0] v);
    if (v == {SYM_CNT_W{1'b1}})
      return v;
    return v + SYM_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sym_shift_in.sv
// Serial-to-parallel collector: shifts bits in MSB first and counts them.
// 'full' flags that the bit accepted this cycle completes an N-bit word,
// so the caller can move on without an extra cycle of latency.
module sym_shift_in #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         bit_in,
  output logic [N-1:0] sreg,
  output logic         full
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] cnt;

  // Shift register and accepted-bit counter; clear wins over a same-cycle bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      sreg <= {sreg[N-2:0], bit_in};
      cnt  <= cnt + CW'(1);
    end
  end

  assign full = en && !clr && (cnt == CW'(N - 1));

endmodule

// File: rtl/sym_word_loader.sv
// Framing stage ahead of the symmetry detector: assembles a serial word,
// hands it over with a one-cycle load pulse, waits for the verdict and
// reports it, keeping a saturating symmetric-word count and sticky errors.
module sym_word_loader
  import sym_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 ser_in,
  input  logic                 ser_valid,
  input  logic                 det_busy,
  input  logic                 det_done,
  input  logic                 det_symmetry,
  output logic                 ready,
  output logic                 load,
  output logic [N-1:0]         data_out,
  output logic                 result_valid,
  output logic                 result_sym,
  output logic [SYM_CNT_W-1:0] sym_count,
  output logic                 overrun,
  output logic                 timeout_err
);

  localparam int WW = $clog2(TIMEOUT + 1);

  state_t        state;
  state_t        state_nxt;
  logic [WW-1:0] wcnt;
  logic [N-1:0]  sreg;
  logic          word_full;
  logic          sh_clr;
  logic          sh_en;
  logic          wait_expired;
  logic          in_flight;

  // A frame_start in SHIFT restarts the word and drops that cycle's bit.
  assign sh_clr = frame_start && (state == ST_IDLE || state == ST_SHIFT);
  assign sh_en  = (state == ST_SHIFT) && ser_valid && !frame_start;

  // WAIT cycles are numbered from 1; wcnt holds (cycle - 1).
  assign wait_expired = (wcnt == WW'(TIMEOUT - 1));
  assign in_flight    = (state == ST_ISSUE) || (state == ST_LOAD) || (state == ST_WAIT);

  sym_shift_in #(.N(N)) u_shift (
    .clk    (clk),
    .rst    (rst),
    .clr    (sh_clr),
    .en     (sh_en),
    .bit_in (ser_in),
    .sreg   (sreg),
    .full   (word_full)
  );

  // Next-state decode for the framing sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (frame_start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (word_full) state_nxt = ST_ISSUE;
      ST_ISSUE: if (!det_busy) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_WAIT;
      ST_WAIT:  if (det_done || wait_expired) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Word hand-off, wait counter, verdict capture and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out     <= '0;
      wcnt         <= '0;
      result_valid <= 1'b0;
      result_sym   <= 1'b0;
      sym_count    <= '0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (state == ST_ISSUE && !det_busy)
        data_out <= sreg;
      if (state == ST_LOAD)
        wcnt <= '0;
      else if (state == ST_WAIT && !det_done && !wait_expired)
        wcnt <= wcnt + WW'(1);
      if (state == ST_WAIT && det_done) begin
        result_valid <= 1'b1;
        result_sym   <= det_symmetry;
        if (det_symmetry)
          sym_count <= sat_inc(sym_count);
      end
      if (state == ST_WAIT && !det_done && wait_expired)
        timeout_err <= 1'b1;
      if (frame_start && in_flight)
        overrun <= 1'b1;
    end
  end

  assign ready = (state == ST_IDLE);
  assign load  = (state == ST_LOAD);

endmodule

// File: tb/tb_sym_word_loader.sv
// Directed-plus-random bench for sym_word_loader with a transaction-level
// reference: the expected word is rebuilt from the bits actually driven,
// and latencies, counts and flags follow the documented cycle rules.
module tb_sym_word_loader;

  localparam int N       = 8;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_start = 1'b0;
  logic       ser_in = 1'b0;
  logic       ser_valid = 1'b0;
  logic       det_busy = 1'b0;
  logic       det_done = 1'b0;
  logic       det_symmetry = 1'b0;
  logic       ready;
  logic       load;
  logic [N-1:0] data_out;
  logic       result_valid;
  logic       result_sym;
  logic [7:0] sym_count;
  logic       overrun;
  logic       timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  // reference state
  logic [7:0] m_word;
  logic [7:0] m_last;
  int         m_count;
  logic       m_sym;
  logic       m_ovr;
  logic       m_to;

  sym_word_loader #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .ser_in       (ser_in),
    .ser_valid    (ser_valid),
    .det_busy     (det_busy),
    .det_done     (det_done),
    .det_symmetry (det_symmetry),
    .ready        (ready),
    .load         (load),
    .data_out     (data_out),
    .result_valid (result_valid),
    .result_sym   (result_sym),
    .sym_count    (sym_count),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_load"}, 32'(load), 32'd0);
    chk({tag, "_data"}, 32'(data_out), 32'd0);
    chk({tag, "_rv"}, 32'(result_valid), 32'd0);
    chk({tag, "_rsym"}, 32'(result_sym), 32'd0);
    chk({tag, "_cnt"}, 32'(sym_count), 32'd0);
    chk({tag, "_ovr"}, 32'(overrun), 32'd0);
    chk({tag, "_to"}, 32'(timeout_err), 32'd0);
  endtask

  task automatic model_reset();
    m_word = 0; m_last = 0; m_count = 0; m_sym = 0; m_ovr = 0; m_to = 0;
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    frame_start = 0; ser_valid = 0; det_busy = 0; det_done = 0;
    #1;
    model_reset();
    chk_reset_vals(tag);
    tick();
    rst = 1'b0;
    tick();
  endtask

  // frame_start, then N bits with up to maxgap idle cycles before each one
  task automatic shift_word(input logic [7:0] w, input int maxgap, inout int gaps);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    m_word = 0;
    chk("ready_low_in_shift", 32'(ready), 32'd0);
    for (int i = 7; i >= 0; i--) begin
      int g;
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      ser_valid = 1'b0;
      repeat (g) tick();
      gaps += g;
      ser_valid = 1'b1;
      ser_in    = w[i];
      m_word    = {m_word[6:0], w[i]};
      tick();
    end
    ser_valid = 1'b0;
  endtask

  // full transaction; delay < 0 means the detector never answers
  task automatic do_word(input logic [7:0] w, input int maxgap, input int busy,
                         input int delay, input logic sym, input bit fs_wait);
    int gaps;
    int lat;
    gaps = 0;
    shift_word(w, maxgap, gaps);
    det_busy = 1'b1;
    repeat (busy) begin
      tick();
      chk("load_low_while_busy", 32'(load), 32'd0);
    end
    det_busy = 1'b0;
    tick();
    lat = 1 + N + gaps + busy + 1;
    chk("load_pulse", 32'(load), 32'd1);
    chk("load_latency", 32'(lat), 32'(N + 2 + gaps + busy));
    chk("data_out_word", 32'(data_out), 32'(m_word));
    m_last = m_word;
    // det_done during LOAD must be ignored
    det_done = 1'b1;
    det_symmetry = ~sym;
    tick();
    det_done = 1'b0;
    chk("load_single", 32'(load), 32'd0);
    chk("rv_ignores_load_done", 32'(result_valid), 32'd0);
    if (delay < 0) begin
      repeat (TIMEOUT - 1) tick();
      chk("ready_low_before_timeout", 32'(ready), 32'd0);
      chk("to_before_expiry", 32'(timeout_err), 32'(m_to));
      tick();
      m_to = 1'b1;
      chk("timeout_err", 32'(timeout_err), 32'd1);
      chk("ready_after_timeout", 32'(ready), 32'd1);
      chk("rv_none_on_timeout", 32'(result_valid), 32'd0);
      chk("rsym_kept_on_timeout", 32'(result_sym), 32'(m_sym));
    end else begin
      frame_start = fs_wait;
      repeat (delay) begin
        tick();
        frame_start = 1'b0;
        chk("rv_low_waiting", 32'(result_valid), 32'd0);
      end
      det_done = 1'b1;
      det_symmetry = sym;
      tick();
      det_done = 1'b0;
      frame_start = 1'b0;
      if (fs_wait) m_ovr = 1'b1;
      m_sym = sym;
      if (sym && m_count < 255) m_count++;
      chk("result_valid", 32'(result_valid), 32'd1);
      chk("result_sym", 32'(result_sym), 32'(m_sym));
      chk("sym_count", 32'(sym_count), 32'(m_count));
      chk("ready_after_done", 32'(ready), 32'd1);
      tick();
      chk("result_valid_once", 32'(result_valid), 32'd0);
    end
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("data_out_held", 32'(data_out), 32'(m_last));
  endtask

  initial begin
    int gaps;
    model_reset();
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_init");
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_reset_vals("after_release");

    // contiguous 0x99, symmetric, answer two cycles after load
    do_word(8'h99, 0, 0, 1, 1'b1, 1'b0);
    // gaps on ser_valid, non-symmetric
    do_word(8'hA1, 2, 0, 3, 1'b0, 1'b0);
    // detector busy for 5 cycles in ISSUE
    do_word(8'h5A, 0, 5, 0, 1'b1, 1'b0);

    // restart after 3 bits; the bit offered with the restart is dropped
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ser_valid = 1'b1; ser_in = 1'b1; tick();
    end
    ser_valid = 1'b0;
    do_word(8'h3C, 0, 0, 2, 1'b0, 1'b0);
    chk("overrun_not_on_restart", 32'(overrun), 32'd0);
    // frame_start while waiting for the verdict
    do_word(8'h81, 0, 0, 3, 1'b1, 1'b1);

    // detector never answers
    do_word(8'h42, 0, 0, -1, 1'b0, 1'b0);
    // recovery after timeout
    do_word(8'h18, 1, 1, 0, 1'b1, 1'b0);

    // randomized words
    for (int k = 0; k < 20; k++) begin
      do_word(8'($urandom), 3, int'($urandom_range(3, 0)), int'($urandom_range(5, 0)),
              1'($urandom), 1'b0);
    end

    // saturation of the symmetric-word count
    for (int k = 0; k < 256; k++)
      do_word(8'($urandom), 0, 0, 0, 1'b1, 1'b0);
    chk("sym_count_saturated", 32'(sym_count), 32'd255);

    // reset in the middle of SHIFT
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ser_valid = 1'b1; ser_in = 1'($urandom); tick();
    end
    apply_reset("rst_mid_shift");
    do_word(8'hE7, 0, 0, 0, 1'b1, 1'b0);

    // reset in the middle of WAIT
    gaps = 0;
    shift_word(8'h66, 0, gaps);
    tick();
    chk("load_before_wait_rst", 32'(load), 32'd1);
    tick();
    tick();
    apply_reset("rst_mid_wait");
    chk("no_rv_after_rst", 32'(result_valid), 32'd0);
    do_word(8'h24, 0, 0, 1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sym_word_loader.md
# sym_word_loader

Upstream framing stage for the symmetry detector. Collects an N-bit word from a serial bit stream, then issues a single-cycle load pulse with a stable parallel word. It holds that word until the detector reports done. It returns the detector's verdict as a one-cycle result strobe and keeps a saturating count of symmetric words plus sticky error flags.

## Interface
Parameters:
- N, 8, word width in bits (≥2)
- TIMEOUT, 64, max cycles to wait for det_done after load (≥2)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  begin a new word
- ser_in  in  1  serial data bit, MSB first
- ser_valid  in  1  ser_in valid this cycle
- det_busy  in  1  detector busy
- det_done  in  1  detector finished (pulse or level)
- det_symmetry  in  1  detector verdict, sampled with det_done
- ready  out  1  high in IDLE only
- load  out  1  one-cycle load pulse to detector
- data_out  out  N  assembled word
- result_valid  out  1  one-cycle verdict strobe
- result_sym  out  1  captured verdict
- sym_count  out  8  saturating count of symmetric results
- overrun  out  1  sticky: frame_start while word in flight
- timeout_err  out  1  sticky: det_done never arrived

## Operation
- States: IDLE, SHIFT, ISSUE, LOAD, WAIT. All outputs are registered or decoded from the state register (no input-to-output combinational path).
- IDLE: ready=1. frame_start → SHIFT, bit counter cleared. ser_valid ignored.
- SHIFT: each cycle with ser_valid=1: sreg ← {sreg[N-2:0], ser_in}, cnt++. On the Nth accepted bit → ISSUE. frame_start in SHIFT restarts: cnt←0, bit in same cycle discarded, no flag set.
- ISSUE: data_out ← sreg. det_busy=0 → LOAD; else remain (stall indefinitely).
- LOAD: load=1 for exactly this cycle; wait counter cleared → WAIT.
- WAIT: on det_done=1: result_sym ← det_symmetry, result_valid=1 next cycle, sym_count increments if det_symmetry=1 (saturates at 255) → IDLE. If wait counter reaches TIMEOUT with no det_done: timeout_err←1, result_valid not pulsed → IDLE.
- frame_start in ISSUE, LOAD, or WAIT: ignored for sequencing; overrun←1.
- data_out is stable from the ISSUE exit until the next SHIFT completes.
- Sticky flags clear only on rst.

## Timing
- Reset values: state IDLE, ready=1, load=0, data_out=0, result_valid=0, result_sym=0, sym_count=0, overrun=0, timeout_err=0, cnt=0.
- frame_start at cycle t → SHIFT at t+1; first bit accepted at t+1 at earliest.
- Nth bit accepted at cycle k → ISSUE at k+1; with det_busy=0 at k+1, load high at k+2.
- Minimum frame_start-to-load latency: N+2 cycles.
- det_done is sampled from the cycle after LOAD onward; det_done during LOAD is ignored.
- det_done at cycle d → result_valid, result_sym, sym_count updated at d+1, ready=1 at d+1.
- TIMEOUT counted from first WAIT cycle; expiry at WAIT cycle TIMEOUT.
- rst mid-operation: immediate return to reset values; no load or result_valid glitch.

## Structure
- Shared package sym_pkg: state enum type, SYM_CNT_W=8 constant, default N/TIMEOUT constants.
- One sub-module: sym_shift_in (sreg + bit counter, enable/clear inputs, full flag), reused by other serial front ends.
- FSM, wait counter, result capture, and flags live in sym_word_loader.

## Test plan
- N=8, frame_start then bits 1,0,0,1,1,0,0,1 contiguous, det_busy=0, det_done+det_symmetry=1 two cycles after load → load at frame_start+10, data_out=0x99, result_sym=1, sym_count=1.
- Bits with ser_valid gaps (every other cycle), word 0xA1, det_symmetry=0 → data_out=0xA1 exactly once, result_valid one cycle, sym_count unchanged.
- det_busy held high 5 cycles in ISSUE → load delayed until the cycle after det_busy falls, one pulse only.
- frame_start after 3 bits then 8 fresh bits 0x3C → data_out=0x3C, overrun=0. A second frame_start during WAIT → overrun=1, result still delivered.
- No det_done after load, TIMEOUT=64 → timeout_err=1 after 64 WAIT cycles, ready=1, no result_valid. 256 symmetric words → sym_count=255.
- rst asserted mid-SHIFT and mid-WAIT → all outputs at reset values in the same cycle. The next word completes normally.
